// File: rtl/ctrl_seq_fsm.sv
// Multicycle accumulator-CPU control sequencer: fetch/decode/execute FSM driving
// datapath strobes, with memory wait-state timeout, stack checks and opcode trapping.
module ctrl_seq_fsm #(
  parameter int OPCODE_W   = 3,
  parameter int ALUOP_W    = 3,
  parameter int ALUOP_ADD  = 0,
  parameter int ALUOP_PASS = 3,
  parameter int WAIT_MAX   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                ac_zero,
  input  logic                stack_full,
  input  logic                stack_empty,
  output logic                pc_read,
  output logic                pc_write,
  output logic                inc_pc,
  output logic                ir_read,
  output logic                ir_write,
  output logic                ma_read,
  output logic                ma_write,
  output logic                md_read,
  output logic                md_write,
  output logic                md_write_mem,
  output logic                ac_read,
  output logic                ac_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                stack_read,
  output logic                stack_write,
  output logic                alu_enable,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                instr_done,
  output logic                halted,
  output logic                fault,
  output logic [1:0]          fault_code
);

  localparam int WCW = $clog2(WAIT_MAX + 1);

  typedef enum logic [4:0] {
    F_PC, F_MA, F_INC, F_MEM, F_MD, F_IR, DECODE,
    X_IRA, X_MA, X_MEM, X_MD, X_AC, X_ACR, X_WR,
    X_PCS, X_JMP, X_STK, HALTED, FAULT
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [1:0]     fcode_q, fcode_d;
  logic [1:0]     op_q, op_d;
  logic           live_q;

  logic       legal;
  logic [2:0] opc;
  logic       wait_lim;

  assign legal    = (opcode >> 3) == '0;
  assign opc      = opcode[2:0];
  assign wait_lim = (wait_q == WCW'(WAIT_MAX));

  // live_q keeps every output quiet until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= F_PC;
      wait_q  <= '0;
      fcode_q <= '0;
      op_q    <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fcode_q <= fcode_d;
      op_q    <= op_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    fcode_d = fcode_q;
    op_d    = op_q;
    if (live_q) begin
      unique case (state_q)
        F_PC:   if (run) state_d = F_MA;
        F_MA:   state_d = F_INC;
        F_INC:  state_d = F_MEM;
        F_MD:   state_d = F_IR;
        F_IR:   state_d = DECODE;
        X_IRA:  state_d = X_MA;
        X_MA:   state_d = (op_q == 2'd2) ? X_ACR : X_MEM;
        X_MD:   state_d = X_AC;
        X_ACR:  state_d = X_WR;
        X_PCS:  state_d = X_JMP;
        X_AC, X_JMP, X_STK: state_d = F_PC;
        F_MEM, X_MEM, X_WR: begin
          if (mem_ready) begin
            state_d = (state_q == F_MEM) ? F_MD : (state_q == X_MEM) ? X_MD : F_PC;
          end else if (wait_lim) begin
            state_d = FAULT;
            fcode_d = 2'd3;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        DECODE: begin
          op_d = opc[1:0];
          if (!legal) begin
            state_d = FAULT;
            fcode_d = 2'd1;
          end else begin
            unique case (opc)
              3'd0, 3'd1, 3'd2: state_d = X_IRA;
              3'd3: if (stack_full)  begin state_d = FAULT; fcode_d = 2'd2; end
                    else state_d = X_PCS;
              3'd4: if (stack_empty) begin state_d = FAULT; fcode_d = 2'd2; end
                    else state_d = X_STK;
              3'd5: state_d = X_JMP;
              3'd6: state_d = ac_zero ? X_JMP : F_PC;
              default: state_d = HALTED;
            endcase
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    pc_read = 1'b0; pc_write = 1'b0; inc_pc = 1'b0; ir_read = 1'b0; ir_write = 1'b0;
    ma_read = 1'b0; ma_write = 1'b0; md_read = 1'b0; md_write = 1'b0; md_write_mem = 1'b0;
    ac_read = 1'b0; ac_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    stack_read = 1'b0; stack_write = 1'b0; instr_done = 1'b0;
    aluop      = ALUOP_W'(ALUOP_PASS);
    alu_enable = live_q && (state_q != HALTED) && (state_q != FAULT);
    halted     = live_q && (state_q == HALTED);
    fault      = live_q && (state_q == FAULT);
    fault_code = fcode_q;
    if (live_q) begin
      unique case (state_q)
        F_PC:   pc_read = 1'b1;
        F_MA:   ma_write = 1'b1;
        F_INC:  begin inc_pc = 1'b1; ma_read = 1'b1; end
        F_MEM:  mem_read = 1'b1;
        F_MD:   md_write_mem = 1'b1;
        F_IR:   begin md_read = 1'b1; ir_write = 1'b1; end
        DECODE: instr_done = legal && (opc == 3'd6) && !ac_zero;
        X_IRA:  ir_read = 1'b1;
        X_MA:   ma_write = 1'b1;
        X_MEM:  begin ma_read = 1'b1; mem_read = 1'b1; end
        X_MD:   md_write_mem = 1'b1;
        X_AC: begin
          ac_write   = 1'b1;
          instr_done = 1'b1;
          if (op_q == 2'd0) begin
            ac_read = 1'b1;
            aluop   = ALUOP_W'(ALUOP_ADD);
          end
        end
        X_ACR:  begin ac_read = 1'b1; md_write = 1'b1; end
        X_WR:   begin mem_write = 1'b1; instr_done = mem_ready; end
        X_PCS:  begin pc_read = 1'b1; stack_write = 1'b1; end
        X_JMP:  begin ir_read = 1'b1; pc_write = 1'b1; instr_done = 1'b1; end
        X_STK:  begin stack_read = 1'b1; pc_write = 1'b1; instr_done = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule
